id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg.sv | 190 +++++++++++++++++++
 tb/tb_id_ex_reg.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with valid/ready handshake, load-use hazard detection,
// single-bubble insertion, flush and a saturating bubble counter.
`ifndef Itype_L
`define Itype_L 7'b0000011
`endif
`ifndef NO_OP
`define NO_OP 5'd0
`endif
`ifndef ADD
`define ADD 5'd1
`endif
`ifndef SUB
`define SUB 5'd2
`endif

module id_ex_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid_i,
    output logic              id_ready_o,
    input  logic [4:0]        id_ALUctrl_i,
    input  logic              id_reg_we_i,
    input  logic              id_op_b_sel_i,
    input  logic              id_reg1_RE_i,
    input  logic              id_reg2_RE_i,
    input  logic [6:0]        id_opcode_i,
    input  logic [2:0]        id_func3_i,
    input  logic [4:0]        id_rs1_i,
    input  logic [4:0]        id_rs2_i,
    input  logic [4:0]        id_rd_i,
    input  logic [DATA_W-1:0] id_op_a_i,
    input  logic [DATA_W-1:0] id_op_b_i,
    input  logic [DATA_W-1:0] id_reg2_data_i,
    input  logic [DATA_W-1:0] id_pc_i,
    input  logic              ex_flush_i,
    input  logic              ex_ready_i,
    output logic              ex_valid_o,
    output logic [4:0]        ex_ALUctrl_o,
    output logic              ex_reg_we_o,
    output logic              ex_op_b_sel_o,
    output logic [6:0]        ex_opcode_o,
    output logic [2:0]        ex_func3_o,
    output logic [4:0]        ex_rs1_o,
    output logic [4:0]        ex_rs2_o,
    output logic [4:0]        ex_rd_o,
    output logic [DATA_W-1:0] ex_op_a_o,
    output logic [DATA_W-1:0] ex_op_b_o,
    output logic [DATA_W-1:0] ex_reg2_data_o,
    output logic [DATA_W-1:0] ex_pc_o,
    output logic              ex_is_load_o,
    output logic              load_use_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    localparam logic [6:0] OPC_LOAD = `Itype_L;
    localparam logic [4:0] ALU_NOP  = `NO_OP;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic              valid_q,   valid_d;
    logic [4:0]        alu_q,     alu_d;
    logic              we_q,      we_d;
    logic              bsel_q,    bsel_d;
    logic [6:0]        opc_q,     opc_d;
    logic [2:0]        f3_q,      f3_d;
    logic [4:0]        rs1_q,     rs1_d;
    logic [4:0]        rs2_q,     rs2_d;
    logic [4:0]        rd_q,      rd_d;
    logic [DATA_W-1:0] opa_q,     opa_d;
    logic [DATA_W-1:0] opb_q,     opb_d;
    logic [DATA_W-1:0] r2d_q,     r2d_d;
    logic [DATA_W-1:0] pc_q,      pc_d;
    logic              isld_q,    isld_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    logic load_use, advance, accept;

    // Hazard looks only at registered EX state and ID source indices.
    assign load_use = valid_q & isld_q & we_q & (rd_q != 5'd0) & id_valid_i &
                      ((id_reg1_RE_i & (id_rs1_i == rd_q)) |
                       (id_reg2_RE_i & (id_rs2_i == rd_q)));
    assign advance  = ex_ready_i | ~valid_q;
    assign accept   = id_valid_i & advance & ~load_use & ~ex_flush_i;

    always_comb begin
        valid_d = valid_q;
        alu_d   = alu_q;
        we_d    = we_q;
        bsel_d  = bsel_q;
        opc_d   = opc_q;
        f3_d    = f3_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        r2d_d   = r2d_q;
        pc_d    = pc_q;
        isld_d  = isld_q;
        cnt_d   = cnt_q;
        if (ex_flush_i) begin
            valid_d = 1'b0;
            alu_d   = ALU_NOP;
            we_d    = 1'b0;
            isld_d  = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            alu_d   = id_ALUctrl_i;
            we_d    = id_reg_we_i;
            bsel_d  = id_op_b_sel_i;
            opc_d   = id_opcode_i;
            f3_d    = id_func3_i;
            rs1_d   = id_rs1_i;
            rs2_d   = id_rs2_i;
            rd_d    = id_rd_i;
            opa_d   = id_op_a_i;
            opb_d   = id_op_b_i;
            r2d_d   = id_reg2_data_i;
            pc_d    = id_pc_i;
            isld_d  = (id_opcode_i == OPC_LOAD);
        end else if (advance) begin
            // Bubble: data fields keep stale values, only control is cleared.
            valid_d = 1'b0;
            alu_d   = ALU_NOP;
            we_d    = 1'b0;
            isld_d  = 1'b0;
            if (load_use) cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            alu_q   <= ALU_NOP;
            we_q    <= 1'b0;
            bsel_q  <= 1'b0;
            opc_q   <= '0;
            f3_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            r2d_q   <= '0;
            pc_q    <= '0;
            isld_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            alu_q   <= alu_d;
            we_q    <= we_d;
            bsel_q  <= bsel_d;
            opc_q   <= opc_d;
            f3_q    <= f3_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            r2d_q   <= r2d_d;
            pc_q    <= pc_d;
            isld_q  <= isld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign id_ready_o     = advance & ~load_use & ~ex_flush_i;
    assign load_use_o     = load_use;
    assign ex_valid_o     = valid_q;
    assign ex_ALUctrl_o   = alu_q;
    assign ex_reg_we_o    = we_q;
    assign ex_op_b_sel_o  = bsel_q;
    assign ex_opcode_o    = opc_q;
    assign ex_func3_o     = f3_q;
    assign ex_rs1_o       = rs1_q;
    assign ex_rs2_o       = rs2_q;
    assign ex_rd_o        = rd_q;
    assign ex_op_a_o      = opa_q;
    assign ex_op_b_o      = opb_q;
    assign ex_reg2_data_o = r2d_q;
    assign ex_pc_o        = pc_q;
    assign ex_is_load_o   = isld_q;
    assign bubble_cnt_o   = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: scoreboard of accepted instructions plus a
// reference model of the handshake, hazard, bubble and flush behaviour.
module tb_id_ex_reg;

    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_REG  = 7'b0110011;
    localparam logic [4:0] A_NOP    = 5'd0;
    localparam logic [4:0] A_ADD    = 5'd1;
    localparam logic [4:0] A_SUB    = 5'd2;

    typedef struct packed {
        logic [4:0]  alu;
        logic        we;
        logic        bsel;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] opa;
        logic [31:0] opb;
        logic [31:0] r2d;
        logic [31:0] pc;
        logic        isld;
    } instr_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic idv = 1'b0, exr = 1'b0, fl = 1'b0;
    logic [4:0] alu = '0, rs1 = '0, rs2 = '0, rd = '0;
    logic we = 1'b0, bsel = 1'b0, re1 = 1'b0, re2 = 1'b0;
    logic [6:0] opc = '0;
    logic [2:0] f3 = '0;
    logic [31:0] opa = '0, opb = '0, r2d = '0, pc = '0;

    logic id_ready_o, ex_valid_o, ex_reg_we_o, ex_op_b_sel_o, ex_is_load_o, load_use_o;
    logic [4:0] ex_ALUctrl_o, ex_rs1_o, ex_rs2_o, ex_rd_o;
    logic [6:0] ex_opcode_o;
    logic [2:0] ex_func3_o;
    logic [31:0] ex_op_a_o, ex_op_b_o, ex_reg2_data_o, ex_pc_o;
    logic [15:0] bubble_cnt_o;

    logic s_id_ready_o, s_ex_valid_o, s_ex_reg_we_o, s_ex_op_b_sel_o, s_ex_is_load_o, s_load_use_o;
    logic [4:0] s_ex_ALUctrl_o, s_ex_rs1_o, s_ex_rs2_o, s_ex_rd_o;
    logic [6:0] s_ex_opcode_o;
    logic [2:0] s_ex_func3_o;
    logic [31:0] s_ex_op_a_o, s_ex_op_b_o, s_ex_reg2_data_o, s_ex_pc_o;
    logic [3:0] s_bubble_cnt_o;

    always #5 clk = ~clk;

    id_ex_reg #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid_i(idv), .id_ready_o(id_ready_o),
        .id_ALUctrl_i(alu), .id_reg_we_i(we), .id_op_b_sel_i(bsel),
        .id_reg1_RE_i(re1), .id_reg2_RE_i(re2), .id_opcode_i(opc), .id_func3_i(f3),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rd_i(rd), .id_op_a_i(opa), .id_op_b_i(opb),
        .id_reg2_data_i(r2d), .id_pc_i(pc), .ex_flush_i(fl), .ex_ready_i(exr),
        .ex_valid_o(ex_valid_o), .ex_ALUctrl_o(ex_ALUctrl_o), .ex_reg_we_o(ex_reg_we_o),
        .ex_op_b_sel_o(ex_op_b_sel_o), .ex_opcode_o(ex_opcode_o), .ex_func3_o(ex_func3_o),
        .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o), .ex_op_a_o(ex_op_a_o),
        .ex_op_b_o(ex_op_b_o), .ex_reg2_data_o(ex_reg2_data_o), .ex_pc_o(ex_pc_o),
        .ex_is_load_o(ex_is_load_o), .load_use_o(load_use_o), .bubble_cnt_o(bubble_cnt_o)
    );

    // Narrow-counter copy sharing all inputs, so saturation is reachable quickly.
    id_ex_reg #(.DATA_W(32), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid_i(idv), .id_ready_o(s_id_ready_o),
        .id_ALUctrl_i(alu), .id_reg_we_i(we), .id_op_b_sel_i(bsel),
        .id_reg1_RE_i(re1), .id_reg2_RE_i(re2), .id_opcode_i(opc), .id_func3_i(f3),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rd_i(rd), .id_op_a_i(opa), .id_op_b_i(opb),
        .id_reg2_data_i(r2d), .id_pc_i(pc), .ex_flush_i(fl), .ex_ready_i(exr),
        .ex_valid_o(s_ex_valid_o), .ex_ALUctrl_o(s_ex_ALUctrl_o), .ex_reg_we_o(s_ex_reg_we_o),
        .ex_op_b_sel_o(s_ex_op_b_sel_o), .ex_opcode_o(s_ex_opcode_o), .ex_func3_o(s_ex_func3_o),
        .ex_rs1_o(s_ex_rs1_o), .ex_rs2_o(s_ex_rs2_o), .ex_rd_o(s_ex_rd_o), .ex_op_a_o(s_ex_op_a_o),
        .ex_op_b_o(s_ex_op_b_o), .ex_reg2_data_o(s_ex_reg2_data_o), .ex_pc_o(s_ex_pc_o),
        .ex_is_load_o(s_ex_is_load_o), .load_use_o(s_load_use_o), .bubble_cnt_o(s_bubble_cnt_o)
    );

    int errors = 0;
    int checks = 0;
    instr_t q[$];
    instr_t mi = '0;
    logic mv = 1'b0;
    int bub = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic instr_t cur_id();
        instr_t t;
        t = '{alu: alu, we: we, bsel: bsel, opc: opc, f3: f3, rs1: rs1, rs2: rs2, rd: rd,
              opa: opa, opb: opb, r2d: r2d, pc: pc, isld: (opc == OPC_LOAD)};
        return t;
    endfunction

    function automatic instr_t dut_ex();
        instr_t t;
        t = '{alu: ex_ALUctrl_o, we: ex_reg_we_o, bsel: ex_op_b_sel_o, opc: ex_opcode_o,
              f3: ex_func3_o, rs1: ex_rs1_o, rs2: ex_rs2_o, rd: ex_rd_o, opa: ex_op_a_o,
              opb: ex_op_b_o, r2d: ex_reg2_data_o, pc: ex_pc_o, isld: ex_is_load_o};
        return t;
    endfunction

    task automatic set_id(input logic v, input logic [4:0] a, input logic w, input logic [6:0] o,
                          input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                          input logic e1, input logic e2);
        idv = v; alu = a; we = w; opc = o; rs1 = s1; rs2 = s2; rd = d; re1 = e1; re2 = e2;
        bsel = 1'($urandom); f3 = 3'($urandom);
        opa = $urandom; opb = $urandom; r2d = $urandom; pc = $urandom;
    endtask

    task automatic check_ex(input string tag);
        logic [15:0] e16;
        logic [3:0]  e4;
        e16 = (bub > 65535) ? 16'hFFFF : 16'(bub);
        e4  = (bub > 15) ? 4'hF : 4'(bub);
        chk({tag, ".valid"}, ex_valid_o, mv);
        if (mv) chk({tag, ".fields"}, dut_ex(), mi);
        else    chk({tag, ".ctrl_clr"}, {ex_ALUctrl_o, ex_reg_we_o, ex_is_load_o}, {A_NOP, 2'b00});
        chk({tag, ".bcnt"}, bubble_cnt_o, e16);
        chk({tag, ".bcnt_sat"}, s_bubble_cnt_o, e4);
    endtask

    // One clock cycle with the current ID inputs; checks comb outputs, then state.
    task automatic cyc(input string tag, input logic exr_in, input logic fl_in);
        logic lu, rdy, acc, adv;
        exr = exr_in; fl = fl_in;
        #1;
        lu  = mv & mi.isld & mi.we & (mi.rd != 5'd0) & idv &
              ((re1 & (rs1 == mi.rd)) | (re2 & (rs2 == mi.rd)));
        adv = exr | ~mv;
        rdy = adv & ~lu & ~fl;
        acc = idv & rdy;
        chk({tag, ".load_use"}, load_use_o, lu);
        chk({tag, ".id_ready"}, id_ready_o, rdy);
        if (acc) q.push_back(cur_id());
        @(posedge clk); #1;
        if (fl) begin
            mv = 1'b0; mi.alu = A_NOP; mi.we = 1'b0; mi.isld = 1'b0;
        end else if (acc) begin
            mi = q.pop_front(); mv = 1'b1;
        end else if (adv) begin
            mv = 1'b0; mi.alu = A_NOP; mi.we = 1'b0; mi.isld = 1'b0;
            if (lu) bub++;
        end
        check_ex(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.valid", ex_valid_o, 1'b0);
        chk("reset.fields", dut_ex(), '0);
        chk("reset.bcnt", bubble_cnt_o, 16'd0);
        rst_n = 1'b1;

        set_id(1, A_ADD, 1, OPC_IMM, 5'd1, 5'd0, 5'd5, 1, 0);
        cyc("addi", 1, 0);
        chk("addi.rd", ex_rd_o, 5'd5);
        chk("addi.alu", ex_ALUctrl_o, A_ADD);

        set_id(1, A_ADD, 1, OPC_LOAD, 5'd1, 5'd0, 5'd3, 1, 0);
        cyc("lw3", 1, 0);
        set_id(1, A_ADD, 1, OPC_REG, 5'd3, 5'd4, 5'd8, 1, 1);
        cyc("lu_bubble", 1, 0);
        chk("lu_bubble.cnt1", bubble_cnt_o, 16'd1);
        cyc("lu_accept", 1, 0);

        set_id(1, A_ADD, 1, OPC_LOAD, 5'd1, 5'd0, 5'd0, 1, 0);
        cyc("lw0", 1, 0);
        set_id(1, A_ADD, 1, OPC_REG, 5'd0, 5'd0, 5'd9, 1, 1);
        cyc("rd0_nohaz", 1, 0);

        set_id(1, A_SUB, 1, OPC_REG, 5'd6, 5'd7, 5'd10, 1, 1);
        cyc("sub", 1, 0);
        set_id(1, A_ADD, 1, OPC_REG, 5'd1, 5'd2, 5'd11, 1, 1);
        for (int i = 0; i < 3; i++) cyc("stall", 0, 0);
        cyc("stall_rel", 1, 0);

        set_id(1, A_ADD, 1, OPC_LOAD, 5'd1, 5'd0, 5'd7, 1, 0);
        cyc("lw7", 1, 0);
        set_id(1, A_ADD, 1, OPC_REG, 5'd1, 5'd7, 5'd12, 1, 1);
        cyc("flush_haz", 1, 1);
        chk("flush_haz.we", ex_reg_we_o, 1'b0);

        set_id(1, A_ADD, 1, OPC_LOAD, 5'd1, 5'd0, 5'd4, 1, 0);
        cyc("lw4", 1, 0);
        set_id(1, A_ADD, 1, OPC_REG, 5'd4, 5'd0, 5'd13, 1, 0);
        cyc("haz_stall", 0, 0);
        cyc("haz_stall2", 0, 0);
        cyc("haz_bubble", 1, 0);
        cyc("haz_accept", 1, 0);

        set_id(1, A_ADD, 0, OPC_LOAD, 5'd1, 5'd0, 5'd6, 1, 0);
        cyc("lw_nowe", 1, 0);
        set_id(1, A_ADD, 1, OPC_REG, 5'd6, 5'd6, 5'd14, 1, 1);
        cyc("nowe_nohaz", 1, 0);

        set_id(0, A_ADD, 1, OPC_REG, 5'd0, 5'd0, 5'd0, 0, 0);
        cyc("idle", 1, 0);

        for (int i = 0; i < 16; i++) begin
            set_id(1, A_ADD, 1, OPC_LOAD, 5'd1, 5'd0, 5'd2, 1, 0);
            cyc("sat_lw", 1, 0);
            set_id(1, A_ADD, 1, OPC_REG, 5'd2, 5'd0, 5'd15, 1, 0);
            cyc("sat_bub", 1, 0);
            cyc("sat_acc", 1, 0);
        end
        chk("sat.max", s_bubble_cnt_o, 4'hF);

        set_id(1, A_SUB, 1, OPC_REG, 5'd3, 5'd3, 5'd16, 1, 1);
        cyc("pre_rst", 1, 0);
        #2 rst_n = 1'b0;
        #1;
        mv = 1'b0; mi = '0; bub = 0; q.delete();
        chk("async_rst.valid", ex_valid_o, 1'b0);
        chk("async_rst.fields", dut_ex(), '0);
        chk("async_rst.bcnt", bubble_cnt_o, 16'd0);
        @(posedge clk); #1;
        check_ex("rst_edge");
        rst_n = 1'b1;
        set_id(1, A_ADD, 1, OPC_IMM, 5'd2, 5'd0, 5'd17, 1, 0);
        cyc("post_rst", 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
